hack_boot_sequencer: RTL and testbench
======================================

# hack_boot_sequencer

Boot and reload controller for the FPGA top level of the Hack SoC. It releases `hack_external_reset` only after the ROM image has been streamed into QSPI ROM: hold reset, run the file-to-ROM loader, settle, then run the CPU. A button reload restarts the whole sequence, and a loader that never finishes is trapped in an error state. It sits between the debounced buttons, the `load_file_to_rom` run/done handshake and `hack_soc`'s `hack_external_reset`.

## Interface
Parameters:
- `HOLD_CYCLES`, 16: cycles spent in HOLD before loading; must be ≥1.
- `SETTLE_CYCLES`, 4: cycles between loader done and CPU release; must be ≥1.
- `TIMEOUT_CYCLES`, 1048576: maximum cycles in LOAD before ERROR; must be ≥2.
- `CNT_WIDTH`, 21: width of the shared phase counter; must hold `max(all above)-1`.

Ports:
- `clk` in 1: the SoC clock (the 25.125 MHz video-domain clock). Single clock domain.
- `reset` in 1: synchronous, active-high.
- `reload_req` in 1: one-cycle pulse (debounced button strobe) requesting a reboot.
- `loader_done` in 1: done level from the ROM loader.
- `loader_run` out 1: run level to the ROM loader.
- `hack_external_reset` out 1: CPU reset into `hack_soc`.
- `boot_error` out 1: loader timeout flag.
- `boot_busy` out 1: high in HOLD, LOAD or SETTLE.
- `boot_count` out 8: completed boots, saturating.
- `boot_state` out 3: current state, for debug LEDs.

## Operation
- States: HOLD=0, LOAD=1, SETTLE=2, RUN=3, ERROR=4. One counter `cnt` is cleared on every state entry and increments each cycle in HOLD, LOAD and SETTLE.
- HOLD: leave for LOAD when `cnt==HOLD_CYCLES-1`.
- LOAD: `loader_done` is ignored while `cnt==0`, which rejects a stale done level left over from a previous load.
  - If `cnt≥1` and `loader_done` is high, go to SETTLE.
  - Otherwise, if `cnt==TIMEOUT_CYCLES-1`, go to ERROR. Done takes priority over timeout in the same cycle.
- SETTLE: go to RUN when `cnt==SETTLE_CYCLES-1`. On entry to RUN, `boot_count` increments, saturating at 255.
- RUN: `reload_req` goes to HOLD.
- ERROR: `reload_req` goes to HOLD and clears `boot_error`.
- `reload_req` is ignored in HOLD, LOAD and SETTLE.
- `reset` forces HOLD from any state, with `cnt=0` and `boot_count=0`.
- Output decode, all registered and derived from the next-state value so each changes on the same edge as the state:
  - `loader_run=1` only in LOAD.
  - `hack_external_reset=0` only in RUN.
  - `boot_error=1` only in ERROR.
  - `boot_busy=1` in HOLD, LOAD and SETTLE.
  - `boot_state` = state encoding.
- Reset values: HOLD state, `loader_run=0`, `hack_external_reset=1`, `boot_error=0`, `boot_busy=1`, `boot_count=0`, `boot_state=0`.

## Timing
- Cycle 0 is the first edge with `reset` low.
  - HOLD occupies cycles 0..HOLD_CYCLES-1.
  - `loader_run` rises at cycle HOLD_CYCLES.
- Done sampled high at LOAD cycle k (k≥1, `cnt==k`):
  - `loader_run` falls on the next edge.
  - RUN and `hack_external_reset=0` follow SETTLE_CYCLES cycles after that.
- Timeout: ERROR is entered exactly TIMEOUT_CYCLES cycles after LOAD entry.
- `reload_req` in RUN or ERROR:
  - `hack_external_reset=1` on the next edge.
  - `loader_run` rises HOLD_CYCLES cycles later.
- `reset` asserted mid-LOAD: `loader_run=0` on the next edge. No partial-load bookkeeping is kept.
- No combinational paths from inputs to outputs.

## Structure
- Shared package `hack_boot_pkg` holds:
  - state encodings `BOOT_HOLD`..`BOOT_ERROR`;
  - `BOOT_STATE_WIDTH=3`;
  - `BOOT_COUNT_WIDTH=8`.
- Single module with no sub-modules. The state register, the phase counter and the output registers all live in one block.
- The top level instantiates it in place of its inline run/reset logic.
  - `loader_run` drives `run`.
  - `loader_done` comes from `done_loading`.
  - `reload_req` = `strobe_btn & debounced_btn`.

## Test plan
Bench parameters: `HOLD_CYCLES=4`, `SETTLE_CYCLES=2`, `TIMEOUT_CYCLES=32`.
- **Nominal boot.** Release reset at cycle 0 and raise `loader_done` at cycle 14 → `loader_run` high cycles 4..14, SETTLE at 15–16, `hack_external_reset=0` from cycle 17, `boot_count=1`.
- **Stale done.** Hold `loader_done` high from cycle 0 → LOAD at 4 ignores done, done is accepted at 5, SETTLE at 6, RUN at 8.
- **Timeout.** Keep `loader_done` low → ERROR at cycle 36, `boot_error=1`, `loader_run=0`, `hack_external_reset=1`. Then pulse `reload_req` → HOLD on the next edge and `boot_error=0`.
- **Reload from RUN.** Pulse `reload_req` one cycle in RUN → `hack_external_reset=1` on the next edge, the full sequence repeats, `boot_count=2`.
- **Ignored and mid-operation events.**
  - Pulse `reload_req` during LOAD → no effect.
  - Assert `reset` at LOAD cycle 10 → HOLD, `loader_run=0` and `boot_count=0` on the next edge.
- **Saturation.** 260 reload/done cycles → `boot_count` stays at 255.

Source files
------------

// File: rtl/hack_boot_pkg.sv
// Shared encodings and widths for the Hack SoC boot/reload sequencer.
package hack_boot_pkg;

  localparam int unsigned BOOT_STATE_WIDTH = 3;
  localparam int unsigned BOOT_COUNT_WIDTH = 8;

  localparam logic [BOOT_STATE_WIDTH-1:0] BOOT_HOLD   = 3'd0;
  localparam logic [BOOT_STATE_WIDTH-1:0] BOOT_LOAD   = 3'd1;
  localparam logic [BOOT_STATE_WIDTH-1:0] BOOT_SETTLE = 3'd2;
  localparam logic [BOOT_STATE_WIDTH-1:0] BOOT_RUN    = 3'd3;
  localparam logic [BOOT_STATE_WIDTH-1:0] BOOT_ERROR  = 3'd4;

endpackage

// File: rtl/hack_boot_sequencer.sv
// Boot/reload controller: hold CPU reset, stream the ROM image via the loader,
// settle, then release the CPU. Loader timeouts park the sequencer in ERROR.
module hack_boot_sequencer
  import hack_boot_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_WIDTH      = 21
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reload_req,
  input  logic                        loader_done,
  output logic                        loader_run,
  output logic                        hack_external_reset,
  output logic                        boot_error,
  output logic                        boot_busy,
  output logic [BOOT_COUNT_WIDTH-1:0] boot_count,
  output logic [BOOT_STATE_WIDTH-1:0] boot_state
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = '0;
  localparam logic [BOOT_COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [BOOT_STATE_WIDTH-1:0] state;
  logic [BOOT_STATE_WIDTH-1:0] state_nx;
  logic [CNT_WIDTH-1:0]        cnt;

  // Next-state decode; done is ignored on the first LOAD cycle to reject a stale level
  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT_HOLD:   if (cnt == HOLD_LAST) state_nx = BOOT_LOAD;
      BOOT_LOAD: begin
        if ((cnt != CNT_ZERO) && loader_done) state_nx = BOOT_SETTLE;
        else if (cnt == TIMEOUT_LAST)         state_nx = BOOT_ERROR;
      end
      BOOT_SETTLE: if (cnt == SETTLE_LAST) state_nx = BOOT_RUN;
      BOOT_RUN:    if (reload_req) state_nx = BOOT_HOLD;
      BOOT_ERROR:  if (reload_req) state_nx = BOOT_HOLD;
      default:     state_nx = BOOT_HOLD;
    endcase
  end

  // State, phase counter and outputs all registered off the next-state value
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= BOOT_HOLD;
      cnt                 <= '0;
      loader_run          <= 1'b0;
      hack_external_reset <= 1'b1;
      boot_error          <= 1'b0;
      boot_busy           <= 1'b1;
      boot_count          <= '0;
      boot_state          <= BOOT_HOLD;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        cnt <= '0;
      else if ((state == BOOT_HOLD) || (state == BOOT_LOAD) || (state == BOOT_SETTLE))
        cnt <= cnt + CNT_WIDTH'(1);

      if ((state == BOOT_SETTLE) && (state_nx == BOOT_RUN) && (boot_count != COUNT_MAX))
        boot_count <= boot_count + BOOT_COUNT_WIDTH'(1);

      loader_run          <= (state_nx == BOOT_LOAD);
      hack_external_reset <= (state_nx != BOOT_RUN);
      boot_error          <= (state_nx == BOOT_ERROR);
      boot_busy           <= (state_nx == BOOT_HOLD) || (state_nx == BOOT_LOAD) ||
                             (state_nx == BOOT_SETTLE);
      boot_state          <= state_nx;
    end
  end

endmodule

// File: tb/tb_hack_boot_sequencer.sv
// Directed + randomized bench for hack_boot_sequencer against a phase/elapsed-time model.
module tb_hack_boot_sequencer;

  localparam int H = 4;
  localparam int S = 2;
  localparam int T = 32;
  // phase numbering follows the documented debug encoding
  localparam int P_HOLD = 0, P_LOAD = 1, P_SETTLE = 2, P_RUN = 3, P_ERROR = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reload_req = 1'b0;
  logic       loader_done = 1'b0;
  logic       loader_run;
  logic       hack_external_reset;
  logic       boot_error;
  logic       boot_busy;
  logic [7:0] boot_count;
  logic [2:0] boot_state;

  hack_boot_sequencer #(
    .HOLD_CYCLES(H), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_WIDTH(21)
  ) dut (
    .clk(clk), .reset(reset), .reload_req(reload_req), .loader_done(loader_done),
    .loader_run(loader_run), .hack_external_reset(hack_external_reset),
    .boot_error(boot_error), .boot_busy(boot_busy),
    .boot_count(boot_count), .boot_state(boot_state)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;      // index of the cycle whose state is currently visible
  int mphase = P_HOLD;
  int mentry = 0;   // cycle at which the current phase began
  int mcount = 0;

  task automatic check(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic enter(input int p);
    mphase = p;
    mentry = cyc + 1;
  endtask

  // Apply one edge of stimulus, advance the model, then compare every output.
  task automatic tick(input bit r, input bit d, input bit rst);
    int el;
    reload_req  = r;
    loader_done = d;
    reset       = rst;
    @(posedge clk);
    el = cyc - mentry;
    if (rst) begin
      enter(P_HOLD);
      mcount = 0;
    end else begin
      case (mphase)
        P_HOLD:   if (el == H - 1) enter(P_LOAD);
        P_LOAD: begin
          if (el >= 1 && d)       enter(P_SETTLE);
          else if (el == T - 1)   enter(P_ERROR);
        end
        P_SETTLE: if (el == S - 1) begin
          enter(P_RUN);
          if (mcount < 255) mcount++;
        end
        default:  if (r) enter(P_HOLD);
      endcase
    end
    cyc++;
    @(negedge clk);
    check("loader_run", int'(loader_run), int'(mphase == P_LOAD));
    check("hack_external_reset", int'(hack_external_reset), int'(mphase != P_RUN));
    check("boot_error", int'(boot_error), int'(mphase == P_ERROR));
    check("boot_busy", int'(boot_busy), int'(mphase <= P_SETTLE));
    check("boot_state", int'(boot_state), mphase);
    check("boot_count", int'(boot_count), mcount);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    cyc = 0;
    mentry = 0;
  endtask

  int guard;

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_state", int'(boot_state), 0);
    check("reset_hack_reset", int'(hack_external_reset), 1);
    check("reset_busy", int'(boot_busy), 1);

    // Nominal boot: done at cycle 14
    while (cyc < 14) tick(1'b0, 1'b0, 1'b0);
    check("nom_run_at_14", int'(loader_run), 1);
    tick(1'b0, 1'b1, 1'b0);
    check("nom_run_fall_15", int'(loader_run), 0);
    check("nom_settle_15", int'(boot_state), 2);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("nom_cpu_out_17", int'(hack_external_reset), 0);
    check("nom_count_1", int'(boot_count), 1);

    // Reload from RUN, with a reload pulse during LOAD that must be ignored
    tick(1'b1, 1'b0, 1'b0);
    check("reload_hack_reset", int'(hack_external_reset), 1);
    for (int i = 0; i < H; i++) tick(1'b0, 1'b0, 1'b0);
    check("reload_load", int'(loader_run), 1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("reload_in_load_ignored", int'(boot_state), 1);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < S; i++) tick(1'b0, 1'b0, 1'b0);
    check("reload_count_2", int'(boot_count), 2);
    check("reload_running", int'(hack_external_reset), 0);

    // Stale done held high from cycle 0
    do_reset();
    while (cyc < 5) tick(1'b0, 1'b1, 1'b0);
    check("stale_ignored_5", int'(boot_state), 1);
    tick(1'b0, 1'b1, 1'b0);
    check("stale_settle_6", int'(boot_state), 2);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("stale_run_8", int'(boot_state), 3);

    // Loader timeout
    do_reset();
    while (cyc < 36) tick(1'b0, 1'b0, 1'b0);
    check("timeout_error_36", int'(boot_error), 1);
    check("timeout_run_low", int'(loader_run), 0);
    check("timeout_hack_reset", int'(hack_external_reset), 1);
    tick(1'b1, 1'b0, 1'b0);
    check("timeout_reload_hold", int'(boot_state), 0);
    check("timeout_error_clear", int'(boot_error), 0);

    // Reset asserted at LOAD cycle 10
    do_reset();
    while (cyc < H + 10) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("midload_run_low", int'(loader_run), 0);
    check("midload_hold", int'(boot_state), 0);
    check("midload_count", int'(boot_count), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      tick(1'(($urandom % 8) == 0), 1'(($urandom % 4) == 0), 1'(($urandom % 151) == 0));

    // Saturation of boot_count
    do_reset();
    for (int b = 0; b < 260; b++) begin
      guard = 0;
      while (mphase != P_RUN && guard < 50) begin
        tick(1'b0, 1'b1, 1'b0);
        guard++;
      end
      check("sat_reached_run", int'(boot_state), 3);
      tick(1'b1, 1'b1, 1'b0);
    end
    guard = 0;
    while (mphase != P_RUN && guard < 50) begin
      tick(1'b0, 1'b1, 1'b0);
      guard++;
    end
    check("sat_count_255", int'(boot_count), 255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
